ahb_mtx_decoder: RTL and testbench

AHB_MTX_DECODER -- requirements
Module: ahb_mtx_decoder

---
 rtl/ahb_mtx_decoder.sv | 111 +++++++++++
 tb/tb_ahb_mtx_decoder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ahb_mtx_decoder.sv
// AHB matrix output-stage decoder: address-phase slave selects plus a data-phase
// response/read-data mux steered by a registered copy of the selected target.
module ahb_mtx_decoder #(
  parameter logic [31:0] BASE0 = 32'h0000_0000,
  parameter logic [31:0] MASK0 = 32'hE000_0000,
  parameter logic [31:0] BASE1 = 32'h2000_0000,
  parameter logic [31:0] MASK1 = 32'hE000_0000,
  parameter logic [31:0] BASE2 = 32'h4000_0000,
  parameter logic [31:0] MASK2 = 32'hF000_0000
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSELS,
  input  logic [31:0] HADDRS,
  input  logic [1:0]  HTRANSS,
  output logic        HSELM0,
  output logic        HSELM1,
  output logic        HSELM2,
  output logic        HSELDEF,
  input  logic        HREADYOUTM0,
  input  logic        HREADYOUTM1,
  input  logic        HREADYOUTM2,
  input  logic [1:0]  HRESPM0,
  input  logic [1:0]  HRESPM1,
  input  logic [1:0]  HRESPM2,
  input  logic [31:0] HRDATAM0,
  input  logic [31:0] HRDATAM1,
  input  logic [31:0] HRDATAM2,
  input  logic        HREADYOUTDEF,
  input  logic [1:0]  HRESPDEF,
  output logic        HREADYOUTS,
  output logic [1:0]  HRESPS,
  output logic [31:0] HRDATAS
);

  typedef enum logic [2:0] {
    DSEL_NONE,
    DSEL_M0,
    DSEL_M1,
    DSEL_M2,
    DSEL_DEF
  } dsel_t;

  dsel_t addr_tgt;
  dsel_t dsel;
  dsel_t dsel_next;

  logic hit0, hit1, hit2;

  assign hit0 = (HADDRS & MASK0) == BASE0;
  assign hit1 = (HADDRS & MASK1) == BASE1;
  assign hit2 = (HADDRS & MASK2) == BASE2;

  // Overlapping regions resolve to the lowest index; no hit falls to the default slave.
  always_comb begin
    // NOTE: assign a default before any branch so no path through always_comb infers a latch.
    addr_tgt = DSEL_DEF;
    if (hit0)      addr_tgt = DSEL_M0;
    else if (hit1) addr_tgt = DSEL_M1;
    else if (hit2) addr_tgt = DSEL_M2;
  end

  assign HSELM0  = HSELS && (addr_tgt == DSEL_M0);
  assign HSELM1  = HSELS && (addr_tgt == DSEL_M1);
  assign HSELM2  = HSELS && (addr_tgt == DSEL_M2);
  assign HSELDEF = HSELS && (addr_tgt == DSEL_DEF);

  // A stalled data phase keeps its target; IDLE/BUSY or deselect opens no data phase.
  always_comb begin
    dsel_next = dsel;
    if (HREADYOUTS) begin
      if (HSELS && HTRANSS[1]) dsel_next = addr_tgt;
      else                     dsel_next = DSEL_NONE;
    end
  end

  always_ff @(posedge HCLK) begin
    // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
    if (!HRESETn) dsel <= DSEL_NONE;
    else          dsel <= dsel_next;
  end

  always_comb begin
    HREADYOUTS = 1'b1;
    HRESPS     = 2'b00;
    HRDATAS    = 32'h0;
    unique case (dsel)
      DSEL_M0: begin
        HREADYOUTS = HREADYOUTM0;
        HRESPS     = HRESPM0;
        HRDATAS    = HRDATAM0;
      end
      DSEL_M1: begin
        HREADYOUTS = HREADYOUTM1;
        HRESPS     = HRESPM1;
        HRDATAS    = HRDATAM1;
      end
      DSEL_M2: begin
        HREADYOUTS = HREADYOUTM2;
        HRESPS     = HRESPM2;
        HRDATAS    = HRDATAM2;
      end
      DSEL_DEF: begin
        HREADYOUTS = HREADYOUTDEF;
        HRESPS     = HRESPDEF;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahb_mtx_decoder.sv
// Bench for ahb_mtx_decoder: decode table, directed multi-cycle sequences and a
// randomized run against a behavioural model of the address map and data phase.
module tb_ahb_mtx_decoder;

  logic             HCLK;
  logic             HRESETn;
  logic             HSELS;
  logic [31:0]      HADDRS;
  logic [1:0]       HTRANSS;
  logic             HSELM0, HSELM1, HSELM2, HSELDEF;
  logic [2:0]       rdy_m;
  logic [2:0][1:0]  resp_m;
  logic [2:0][31:0] rdata_m;
  logic             rdy_def;
  logic [1:0]       resp_def;
  logic             HREADYOUTS;
  logic [1:0]       HRESPS;
  logic [31:0]      HRDATAS;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] BASES [3] = '{32'h0000_0000, 32'h2000_0000, 32'h4000_0000};
  localparam logic [31:0] MASKS [3] = '{32'hE000_0000, 32'hE000_0000, 32'hF000_0000};

  ahb_mtx_decoder dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS), .HTRANSS(HTRANSS),
    .HSELM0(HSELM0), .HSELM1(HSELM1), .HSELM2(HSELM2), .HSELDEF(HSELDEF),
    .HREADYOUTM0(rdy_m[0]), .HREADYOUTM1(rdy_m[1]), .HREADYOUTM2(rdy_m[2]),
    .HRESPM0(resp_m[0]), .HRESPM1(resp_m[1]), .HRESPM2(resp_m[2]),
    .HRDATAM0(rdata_m[0]), .HRDATAM1(rdata_m[1]), .HRDATAM2(rdata_m[2]),
    .HREADYOUTDEF(rdy_def), .HRESPDEF(resp_def),
    .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS), .HRDATAS(HRDATAS)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        hsel;
    logic [31:0] addr;
    logic [3:0]  exp_sel;   // {DEF, M2, M1, M0}
  } dec_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    HSELS    = 1'b0;
    HADDRS   = 32'h0;
    HTRANSS  = 2'b00;
    rdy_m    = 3'b111;
    resp_m   = '0;
    rdata_m  = '0;
    rdy_def  = 1'b1;
    resp_def = 2'b00;
  endtask

  // Inputs are driven 1 ns after the rising edge; outputs are sampled mid-cycle.
  task automatic cyc_chk(input string name, input logic [3:0] esel, input logic erdy,
                         input logic [1:0] eresp, input logic [31:0] edata);
    #4;
    check({name, " sel"},   {28'h0, HSELDEF, HSELM2, HSELM1, HSELM0}, {28'h0, esel});
    check({name, " ready"}, {31'h0, HREADYOUTS}, {31'h0, erdy});
    check({name, " resp"},  {30'h0, HRESPS}, {30'h0, eresp});
    check({name, " rdata"}, HRDATAS, edata);
    @(posedge HCLK); #1;
  endtask

  // Reference model: region lookup over the map, lowest index wins; 3 means default slave.
  function automatic int decode(input logic [31:0] a);
    for (int k = 0; k < 3; k++)
      if ((a & MASKS[k]) == BASES[k]) return k;
    return 3;
  endfunction

  dec_vec_t tbl [10];

  initial begin
    int mdl_tgt;   // -1 = no data phase, 0..2 = Mk, 3 = default slave
    logic [3:0]  esel;
    logic        erdy;
    logic [1:0]  eresp;
    logic [31:0] edata;

    tbl[0] = '{1'b1, 32'h0000_0000, 4'b0001};
    tbl[1] = '{1'b1, 32'h1FFF_FFFC, 4'b0001};
    tbl[2] = '{1'b1, 32'h2000_0000, 4'b0010};
    tbl[3] = '{1'b1, 32'h3FFF_FFFF, 4'b0010};
    tbl[4] = '{1'b1, 32'h4000_0000, 4'b0100};
    tbl[5] = '{1'b1, 32'h4FFF_FFFF, 4'b0100};
    tbl[6] = '{1'b1, 32'h5000_0000, 4'b1000};
    tbl[7] = '{1'b1, 32'hFFFF_FFFF, 4'b1000};
    tbl[8] = '{1'b0, 32'h2000_0000, 4'b0000};
    tbl[9] = '{1'b0, 32'h8000_0000, 4'b0000};

    idle();
    HRESETn = 1'b0;
    @(posedge HCLK); #1;
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    cyc_chk("reset", 4'b0000, 1'b1, 2'b00, 32'h0);

    // Address decode with IDLE transfers; slaves look busy so any leak into the data phase shows.
    foreach (tbl[i]) begin
      idle();
      rdy_m    = 3'b000;
      rdata_m  = {32'hAAAA_0002, 32'hAAAA_0001, 32'hAAAA_0000};
      rdy_def  = 1'b0;
      HSELS    = tbl[i].hsel;
      HADDRS   = tbl[i].addr;
      cyc_chk($sformatf("decode[%0d]", i), tbl[i].exp_sel, 1'b1, 2'b00, 32'h0);
    end

    // M1 read with two wait states; a pending NONSEQ to M2 must not disturb the stall.
    idle();
    HSELS = 1'b1; HADDRS = 32'h2000_0010; HTRANSS = 2'b10;
    cyc_chk("m1 addr", 4'b0010, 1'b1, 2'b00, 32'h0);
    HADDRS = 32'h4000_0000; rdy_m[1] = 1'b0; rdata_m[2] = 32'h5555_5555;
    cyc_chk("m1 wait1", 4'b0100, 1'b0, 2'b00, 32'h0);
    cyc_chk("m1 wait2", 4'b0100, 1'b0, 2'b00, 32'h0);
    rdy_m[1] = 1'b1; rdata_m[1] = 32'hDEAD_BEEF;
    cyc_chk("m1 data", 4'b0100, 1'b1, 2'b00, 32'hDEAD_BEEF);
    idle(); rdata_m[2] = 32'h3333_3333; rdata_m[1] = 32'h1234_5678;
    cyc_chk("m2 after stall", 4'b0000, 1'b1, 2'b00, 32'h3333_3333);

    // Default slave two-cycle ERROR, read data forced to zero.
    idle();
    HSELS = 1'b1; HADDRS = 32'h8000_0000; HTRANSS = 2'b10;
    cyc_chk("def addr", 4'b1000, 1'b1, 2'b00, 32'h0);
    idle(); rdy_def = 1'b0; resp_def = 2'b01; rdata_m = {3{32'hFFFF_FFFF}};
    cyc_chk("def err1", 4'b0000, 1'b0, 2'b01, 32'h0);
    rdy_def = 1'b1;
    cyc_chk("def err2", 4'b0000, 1'b1, 2'b01, 32'h0);

    // Back-to-back M0 then M2.
    idle();
    HSELS = 1'b1; HADDRS = 32'h0000_0004; HTRANSS = 2'b10;
    cyc_chk("b2b a0", 4'b0001, 1'b1, 2'b00, 32'h0);
    HADDRS = 32'h4000_0000; rdata_m[0] = 32'h1111_0000; rdata_m[2] = 32'h2222_0000;
    cyc_chk("b2b d0", 4'b0100, 1'b1, 2'b00, 32'h1111_0000);
    idle(); rdata_m[0] = 32'h1111_0000; rdata_m[2] = 32'h2222_0000;
    cyc_chk("b2b d2", 4'b0000, 1'b1, 2'b00, 32'h2222_0000);

    // Reset during an M0 wait state; selects still follow inputs while in reset.
    idle();
    HSELS = 1'b1; HADDRS = 32'h0000_0000; HTRANSS = 2'b10;
    cyc_chk("rst a0", 4'b0001, 1'b1, 2'b00, 32'h0);
    HADDRS = 32'h4000_0000; rdy_m[0] = 1'b0; resp_m[0] = 2'b01; HRESETn = 1'b0;
    cyc_chk("rst wait", 4'b0100, 1'b0, 2'b01, 32'h0);
    HRESETn = 1'b1; HSELS = 1'b0; HTRANSS = 2'b00;
    cyc_chk("rst abandon", 4'b0000, 1'b1, 2'b00, 32'h0);

    // IDLE transfer selects M0 but opens no data phase.
    idle();
    HSELS = 1'b1; HADDRS = 32'h0000_0000; HTRANSS = 2'b00;
    cyc_chk("idle a0", 4'b0001, 1'b1, 2'b00, 32'h0);
    idle(); rdy_m[0] = 1'b0; resp_m[0] = 2'b01; rdata_m[0] = 32'h7777_7777;
    cyc_chk("idle d", 4'b0000, 1'b1, 2'b00, 32'h0);

    // Randomized run against the model, starting from a known reset state.
    idle();
    HRESETn = 1'b0;
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    mdl_tgt = -1;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] pick;
      HRESETn = ($urandom_range(0, 24) != 0);
      HSELS   = $urandom_range(0, 3) != 0;
      HTRANSS = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       pick = 32'h0000_0000;
        1:       pick = 32'h2000_0000;
        2:       pick = 32'h4000_0000;
        3:       pick = 32'h5000_0000;
        4:       pick = 32'h8000_0000;
        default: pick = $urandom;
      endcase
      HADDRS   = pick | ($urandom & 32'h0FFF_FFFF);
      for (int k = 0; k < 3; k++) begin
        rdy_m[k]   = $urandom_range(0, 3) != 0;
        resp_m[k]  = 2'($urandom_range(0, 1));
        rdata_m[k] = $urandom;
      end
      rdy_def  = $urandom_range(0, 3) != 0;
      resp_def = 2'($urandom_range(0, 1));

      esel = HSELS ? 4'(1 << decode(HADDRS)) : 4'b0000;
      case (mdl_tgt)
        -1:      begin erdy = 1'b1;          eresp = 2'b00;            edata = 32'h0; end
        3:       begin erdy = rdy_def;       eresp = resp_def;         edata = 32'h0; end
        default: begin erdy = rdy_m[mdl_tgt]; eresp = resp_m[mdl_tgt]; edata = rdata_m[mdl_tgt]; end
      endcase

      if (!HRESETn)              mdl_tgt = -1;
      else if (erdy)             mdl_tgt = (HSELS && HTRANSS[1]) ? decode(HADDRS) : -1;

      cyc_chk($sformatf("rand[%0d]", n), esel, erdy, eresp, edata);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
